// File: rtl/rs_alu.sv
// Reservation station for the ALU pipe: holds dispatched instructions until both
// operands are present (directly, by CDB wakeup or by dispatch bypass), then issues one per cycle.
module rs_alu #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NAME_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  // dispatch
  input  logic              dispEn,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [TAG_W-1:0]  dispTagA,
  input  logic [TAG_W-1:0]  dispTagB,
  input  logic [DATA_W-1:0] dispDataA,
  input  logic [DATA_W-1:0] dispDataB,
  input  logic [TAG_W-1:0]  dispDestTag,
  input  logic [NAME_W-1:0] dispName,
  output logic              rsFull,
  // common data bus
  input  logic              cdbEn,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData,
  // issue to ALU
  output logic              aluEn,
  output logic [OP_W-1:0]   aluOp,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [TAG_W-1:0]  aluDestTag,
  output logic [NAME_W-1:0] aluName
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag_a;
    logic [DATA_W-1:0] data_a;
    logic [TAG_W-1:0]  tag_b;
    logic [DATA_W-1:0] data_b;
    logic [TAG_W-1:0]  dest_tag;
    logic [NAME_W-1:0] name;
  } entry_t;

  logic [RS_SIZE-1:0] valid_q;
  entry_t             ent_q [RS_SIZE];

  logic [RS_SIZE-1:0] free;
  logic [RS_SIZE-1:0] alloc_oh;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] issue_oh;
  logic               cdb_hit;
  logic               disp_fire;
  logic               issue_any;
  entry_t             disp_ent;
  entry_t             issue_ent;

  assign cdb_hit   = cdbEn && (cdbTag != '0);
  assign rsFull    = &valid_q;
  assign disp_fire = dispEn && !rsFull && !flush;

  // Lowest-index free slot from the pre-edge valid vector, so a slot freed by
  // this cycle's issue only becomes allocatable on the following cycle.
  assign free     = ~valid_q;
  assign alloc_oh = free & (-free);

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = valid_q[i] && (ent_q[i].tag_a == '0) && (ent_q[i].tag_b == '0);
    end
  end

  assign issue_oh  = ready & (-ready);
  assign issue_any = |ready;

  always_comb begin
    issue_ent = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_oh[i]) issue_ent = ent_q[i];
    end
  end

  // Dispatch record, with operands captured straight off the CDB when the
  // producer broadcasts in the same cycle.
  always_comb begin
    disp_ent          = '0;
    disp_ent.op       = dispOp;
    disp_ent.dest_tag = dispDestTag;
    disp_ent.name     = dispName;
    disp_ent.tag_a    = dispTagA;
    disp_ent.data_a   = dispDataA;
    disp_ent.tag_b    = dispTagB;
    disp_ent.data_b   = dispDataB;
    if (cdb_hit && (dispTagA == cdbTag)) begin
      disp_ent.tag_a  = '0;
      disp_ent.data_a = cdbData;
    end
    if (cdb_hit && (dispTagB == cdbTag)) begin
      disp_ent.tag_b  = '0;
      disp_ent.data_b = cdbData;
    end
  end

  // Control state: occupancy and the ALU issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      aluEn      <= 1'b0;
      aluOp      <= '0;
      aluA       <= '0;
      aluB       <= '0;
      aluDestTag <= '0;
      aluName    <= '0;
    end else if (flush) begin
      valid_q <= '0;
      aluEn   <= 1'b0;
    end else begin
      valid_q <= (valid_q & ~issue_oh) | (disp_fire ? alloc_oh : '0);
      aluEn   <= issue_any;
      if (issue_any) begin
        aluOp      <= issue_ent.op;
        aluA       <= issue_ent.data_a;
        aluB       <= issue_ent.data_b;
        aluDestTag <= issue_ent.dest_tag;
        aluName    <= issue_ent.name;
      end
    end
  end

  // NOTE: entry payload is deliberately not reset; every use is qualified by valid_q,
  // which is, and leaving the wide storage reset-free keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (disp_fire && alloc_oh[i]) begin
        ent_q[i] <= disp_ent;
      end else if (valid_q[i] && cdb_hit) begin
        if (ent_q[i].tag_a == cdbTag) begin
          ent_q[i].tag_a  <= '0;
          ent_q[i].data_a <= cdbData;
        end
        if (ent_q[i].tag_b == cdbTag) begin
          ent_q[i].tag_b  <= '0;
          ent_q[i].data_b <= cdbData;
        end
      end
    end
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for the ALU pipe, sitting on the consumer end of the common data bus (CDB). It accepts dispatched instructions whose operands are either values or pending producer tags. It snoops the CDB broadcast to capture missing operands, and issues one ready instruction per cycle to the ALU. The ALU's result then returns to the ROB, which broadcasts it on the CDB.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (power of two not required, ≥2)
- TAG_W, 4, producer tag width; tag value 0 is reserved as "free/ready"
- DATA_W, 32, operand/result width
- OP_W, 6, ALU opcode width
- NAME_W, 5, destination register name width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries (branch mispredict)
- dispEn  in  1  dispatch strobe
- dispOp  in  OP_W  opcode
- dispTagA / dispTagB  in  TAG_W  operand producer tag, 0 = value valid
- dispDataA / dispDataB  in  DATA_W  operand value (used when tag is 0)
- dispDestTag  in  TAG_W  tag of this instruction's result
- dispName  in  NAME_W  destination register name
- rsFull  out  1  all entries valid (combinational from state)
- cdbEn  in  1  CDB broadcast valid
- cdbTag  in  TAG_W  broadcast tag
- cdbData  in  DATA_W  broadcast value
- aluEn  out  1  issue valid (registered)
- aluOp  out  OP_W  issued opcode
- aluA / aluB  out  DATA_W  issued operands
- aluDestTag  out  TAG_W  issued result tag
- aluName  out  NAME_W  issued destination name

## Operation
- Entry state: valid, op, tagA, dataA, tagB, dataB, destTag, name.
- Allocation: lowest-index free entry, selected by a one-hot of free & -free over the pre-edge valid vector. An entry freed by issue this cycle is not reusable until the next cycle.
- Dispatch with rsFull=1: dropped, no state change. Upstream must stall on rsFull.
- Wakeup: on each edge with cdbEn=1 and cdbTag≠0, every valid entry with tagA==cdbTag loads dataA←cdbData and tagA←0. The same applies independently to B.
  - Both operands of one entry may wake together.
  - cdbTag=0 is ignored.
- Dispatch bypass: if dispTagA (or B) equals a same-cycle valid nonzero cdbTag, the entry stores cdbData with tag 0.
- Ready: valid && tagA==0 && tagB==0, evaluated on registered state only.
- Issue: lowest-index ready entry each cycle. On the edge, ALU output registers load that entry's fields, aluEn←1 and the entry's valid←0.
  - With no ready entry, aluEn←0 and the other ALU outputs hold their values.
- Selection is by index, not age. Starvation is acceptable at this size.
- Priority at an edge: rst > flush > {issue, wakeup, dispatch}.
  - flush clears all valid bits and sets aluEn←0; a dispatch in the same cycle is discarded.
  - Issue, wakeup and dispatch proceed concurrently and touch disjoint state, except that wakeup may also update the entry being dispatched, via the bypass.

## Timing
- Reset values: all valid=0, rsFull=0, aluEn=0, aluOp=0, aluA=0, aluB=0, aluDestTag=0, aluName=0.
- Reset is asynchronous and may assert mid-operation; it drops all entries immediately.
- Dispatch with both operands ready at edge k: entry valid after k, aluEn=1 after edge k+1.
- Operand woken by CDB at edge k: entry ready after k, aluEn=1 after edge k+1.
- Bypassed dispatch at edge k behaves as ready dispatch: aluEn after k+1.
- Throughput: one issue and one dispatch per cycle.
- rsFull rises the cycle after the edge that fills the last entry. It falls the cycle after an issue frees an entry.

## Test plan
- Reset mid-stream with 3 valid entries, rst pulse asynchronous to clk → aluEn=0 and rsFull=0 immediately; no issue follows.
- Dispatch op=3, tagA=0/dataA=5, tagB=0/dataB=7, destTag=2 at edge 0 → at edge 1 aluEn=1, aluA=5, aluB=7, aluDestTag=2; aluEn=0 after edge 2.
- Dispatch tagA=4, tagB=0/dataB=1, then cdbEn=1, cdbTag=4, cdbData=0xAA two cycles later → aluA=0xAA, aluB=1 issued one edge after the broadcast. A cdbTag=0 broadcast beforehand causes no issue.
- Dispatch tagA=6 in the same cycle as cdbTag=6, cdbData=9 (bypass) → issues aluA=9 on the next edge.
- Fill all 8 entries with operands waiting on tag 5 → rsFull=1, and a 9th dispatch is dropped. A single broadcast of tag 5 wakes all 8, which then issue in index order 0..7 on 8 consecutive edges with aluEn continuously 1.
- flush asserted with 4 entries waiting and a concurrent dispatch → all cleared, aluEn=0. A later broadcast of the waited tag causes no issue.
